// File: rtl/pll_lock_seq.sv
// pll_lock_seq: PLL lock acquisition sequencer.
// Drives the PLL reset, brake and feedback divider, then compares externally
// measured feedback counts against the expected count to decide lock or failure.
// Optional build macro: PLL_LOCK_SEQ_RELOCK_EN adds loss-of-lock detection
// in LOCKED with an automatic re-acquisition through RESET.
module pll_lock_seq #(
    parameter int RST_CYCLES    = 12,
    parameter int SETTLE_CYCLES = 64,
    parameter int WIN_CYCLES    = 4,
    parameter int TOL           = 2,
    parameter int LOCK_COUNT    = 3,
    parameter int MAX_MEAS      = 16
) (
    input  logic        refclk,
    input  logic        resetn,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  n_cfg,
    input  logic [15:0] fb_count,
    input  logic        fb_count_valid,
    output logic        pll_resetn,
    output logic        pll_brake,
    output logic [7:0]  pll_n,
    output logic        busy,
    output logic        locked,
    output logic        fail
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RESET   = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_MEASURE = 3'd3;
    localparam logic [2:0] S_LOCKED  = 3'd4;
    localparam logic [2:0] S_FAIL    = 3'd5;

    localparam int CYC_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);
    localparam int GOOD_W  = $clog2(LOCK_COUNT + 1);
    localparam int MEAS_W  = $clog2(MAX_MEAS + 1);

    localparam logic [CYC_W-1:0]  RST_LAST    = CYC_W'(RST_CYCLES - 1);
    localparam logic [CYC_W-1:0]  SETTLE_LAST = CYC_W'(SETTLE_CYCLES - 1);
    localparam logic [GOOD_W-1:0] GOOD_MAX    = GOOD_W'(LOCK_COUNT);
    localparam logic [MEAS_W-1:0] MEAS_MAX    = MEAS_W'(MAX_MEAS);
    localparam logic [16:0]       TOL_17      = 17'(TOL);

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [CYC_W-1:0]  cyc_cnt_nx;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_cnt_nx;
    logic [GOOD_W-1:0] good_inc;
    logic [MEAS_W-1:0] meas_cnt;
    logic [MEAS_W-1:0] meas_cnt_nx;
    logic [MEAS_W-1:0] meas_inc;
    logic [7:0]        pll_n_nx;
    logic              can_start;

    logic [15:0]       expected_count;
    logic [16:0]       count_err;
    logic              window_good;

    logic              pll_resetn_nx;
    logic              pll_brake_nx;
    logic              busy_nx;
    logic              locked_nx;
    logic              fail_nx;

`ifdef PLL_LOCK_SEQ_RELOCK_EN
    logic [GOOD_W-1:0] loss_cnt;
    logic [GOOD_W-1:0] loss_cnt_nx;
    logic [GOOD_W-1:0] loss_inc;
`endif

    // Judge the current window: absolute distance between measured and expected count, no wrap.
    always_comb begin
        expected_count = 16'(pll_n) * 16'(WIN_CYCLES);
        if (fb_count >= expected_count) begin
            count_err = {1'b0, fb_count} - {1'b0, expected_count};
        end else begin
            count_err = {1'b0, expected_count} - {1'b0, fb_count};
        end
        window_good = (count_err <= TOL_17);
    end

    // Saturating increments so that no counter can ever wrap back to zero.
    always_comb begin
        good_inc = (good_cnt >= GOOD_MAX) ? good_cnt : good_cnt + 1'b1;
        meas_inc = (meas_cnt >= MEAS_MAX) ? meas_cnt : meas_cnt + 1'b1;
`ifdef PLL_LOCK_SEQ_RELOCK_EN
        loss_inc = (loss_cnt >= GOOD_MAX) ? loss_cnt : loss_cnt + 1'b1;
`endif
    end

    // Next-state and counter logic; stop dominates, then start, then per-state sequencing.
    always_comb begin
        state_nx    = state;
        cyc_cnt_nx  = cyc_cnt;
        good_cnt_nx = good_cnt;
        meas_cnt_nx = meas_cnt;
        pll_n_nx    = pll_n;
`ifdef PLL_LOCK_SEQ_RELOCK_EN
        loss_cnt_nx = loss_cnt;
`endif
        can_start = (state == S_IDLE) || (state == S_LOCKED) || (state == S_FAIL);

        if (stop) begin
            state_nx    = S_IDLE;
            cyc_cnt_nx  = '0;
            good_cnt_nx = '0;
            meas_cnt_nx = '0;
`ifdef PLL_LOCK_SEQ_RELOCK_EN
            loss_cnt_nx = '0;
`endif
        end else if (start && can_start) begin
            cyc_cnt_nx  = '0;
            good_cnt_nx = '0;
            meas_cnt_nx = '0;
`ifdef PLL_LOCK_SEQ_RELOCK_EN
            loss_cnt_nx = '0;
`endif
            if (n_cfg != 8'd0) begin
                state_nx = S_RESET;
                pll_n_nx = n_cfg;
            end else begin
                state_nx = S_FAIL;
            end
        end else begin
            case (state)
                S_RESET: begin
                    if (cyc_cnt == RST_LAST) begin
                        state_nx   = S_SETTLE;
                        cyc_cnt_nx = '0;
                    end else begin
                        cyc_cnt_nx = cyc_cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cyc_cnt == SETTLE_LAST) begin
                        state_nx   = S_MEASURE;
                        cyc_cnt_nx = '0;
                    end else begin
                        cyc_cnt_nx = cyc_cnt + 1'b1;
                    end
                end
                S_MEASURE: begin
                    if (fb_count_valid) begin
                        good_cnt_nx = window_good ? good_inc : '0;
                        meas_cnt_nx = meas_inc;
                        if (good_cnt_nx >= GOOD_MAX) begin
                            state_nx = S_LOCKED;
`ifdef PLL_LOCK_SEQ_RELOCK_EN
                            loss_cnt_nx = '0;
`endif
                        end else if (meas_cnt_nx >= MEAS_MAX) begin
                            state_nx = S_FAIL;
                        end
                    end
                end
                S_LOCKED: begin
`ifdef PLL_LOCK_SEQ_RELOCK_EN
                    if (fb_count_valid) begin
                        if (window_good) begin
                            loss_cnt_nx = '0;
                        end else if (loss_inc >= GOOD_MAX) begin
                            state_nx    = S_RESET;
                            cyc_cnt_nx  = '0;
                            good_cnt_nx = '0;
                            meas_cnt_nx = '0;
                            loss_cnt_nx = '0;
                        end else begin
                            loss_cnt_nx = loss_inc;
                        end
                    end
`else
                    state_nx = S_LOCKED;
`endif
                end
                default: begin
                    state_nx = state;
                end
            endcase
        end
    end

    // Decode the outputs from the next state so every output is a plain register.
    always_comb begin
        pll_resetn_nx = (state_nx == S_SETTLE) || (state_nx == S_MEASURE) || (state_nx == S_LOCKED);
        pll_brake_nx  = (state_nx == S_IDLE) || (state_nx == S_FAIL);
        busy_nx       = (state_nx == S_RESET) || (state_nx == S_SETTLE) || (state_nx == S_MEASURE);
        locked_nx     = (state_nx == S_LOCKED);
        fail_nx       = (state_nx == S_FAIL);
    end

    // State, counters and registered outputs; synchronous reset returns to a braked IDLE.
    always_ff @(posedge refclk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            cyc_cnt    <= '0;
            good_cnt   <= '0;
            meas_cnt   <= '0;
            pll_n      <= 8'd0;
            pll_resetn <= 1'b0;
            pll_brake  <= 1'b1;
            busy       <= 1'b0;
            locked     <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_nx;
            cyc_cnt    <= cyc_cnt_nx;
            good_cnt   <= good_cnt_nx;
            meas_cnt   <= meas_cnt_nx;
            pll_n      <= pll_n_nx;
            pll_resetn <= pll_resetn_nx;
            pll_brake  <= pll_brake_nx;
            busy       <= busy_nx;
            locked     <= locked_nx;
            fail       <= fail_nx;
        end
    end

`ifdef PLL_LOCK_SEQ_RELOCK_EN
    // Loss-of-lock counter, only present when re-acquisition is enabled.
    always_ff @(posedge refclk) begin
        if (!resetn) begin
            loss_cnt <= '0;
        end else begin
            loss_cnt <= loss_cnt_nx;
        end
    end
`endif

endmodule

// File: doc/pll_lock_seq.md
PLL_LOCK_SEQ -- requirements
Module: pll_lock_seq

Interface
REQ-001 Parameter RST_CYCLES, default 12: refclk cycles pll_resetn is held low per attempt.
REQ-002 Parameter SETTLE_CYCLES, default 64: refclk cycles waited after PLL reset release before the first measurement.
REQ-003 Parameter WIN_CYCLES, default 4: refclk cycles per external feedback-count window.
REQ-004 Parameter TOL, default 2: allowed absolute count error per window.
REQ-005 Parameter LOCK_COUNT, default 3: consecutive good windows required to declare lock.
REQ-006 Parameter MAX_MEAS, default 16: measurements per attempt before failing.
REQ-007 refclk  in  1  sole clock; all logic on its rising edge.
REQ-008 resetn  in  1  reset, synchronous and active-low.
REQ-009 start  in  1  one-cycle request to (re)acquire lock.
REQ-010 stop  in  1  one-cycle request to halt the PLL.
REQ-011 n_cfg  in  8  requested feedback divider N.
REQ-012 fb_count  in  16  pclk edges counted over the last window, already synchronised to refclk.
REQ-013 fb_count_valid  in  1  one-cycle strobe qualifying fb_count.
REQ-014 pll_resetn  out  1  PLL reset, active-low.
REQ-015 pll_brake  out  1  PLL brake.
REQ-016 pll_n  out  8  divider driven to the PLL.
REQ-017 busy  out  1  high in RESET, SETTLE and MEASURE.
REQ-018 locked  out  1  high only in LOCKED.
REQ-019 fail  out  1  high only in FAIL.

Function
REQ-020 FSM states: IDLE, RESET, SETTLE, MEASURE, LOCKED, FAIL; all outputs registered.
REQ-021 IDLE, LOCKED or FAIL + start, n_cfg!=0 -> RESET next cycle; pll_n <= n_cfg; good and measurement counters cleared.
REQ-022 start with n_cfg==0 -> FAIL next cycle; pll_n unchanged.
REQ-023 start in RESET, SETTLE or MEASURE ignored.
REQ-024 RESET: pll_resetn=0, pll_brake=0 for exactly RST_CYCLES cycles, then SETTLE.
REQ-025 SETTLE: pll_resetn=1, pll_brake=0 for SETTLE_CYCLES cycles, then MEASURE.
REQ-026 Expected count E = pll_n*WIN_CYCLES, computed 16-bit; error |fb_count-E| computed 17-bit, no wrap.
REQ-027 MEASURE, fb_count_valid: error<=TOL increments good counter, else clears it; measurement counter increments either way.
REQ-028 Good counter reaching LOCK_COUNT -> LOCKED on the next cycle; this takes priority over REQ-029 when both occur on the same strobe.
REQ-029 Otherwise, measurement counter reaching MAX_MEAS -> FAIL.
REQ-030 FAIL: pll_brake=1, pll_resetn=0; state held until start or stop.
REQ-031 stop in any state -> IDLE next cycle: pll_brake=1, pll_resetn=0, counters cleared, pll_n held.
REQ-032 start and stop in the same cycle: stop wins.
REQ-033 fb_count_valid outside MEASURE/LOCKED ignored.
REQ-034 Counters saturate and never wrap.

Reset
REQ-035 resetn low at a rising edge -> IDLE with pll_resetn=0, pll_brake=1, pll_n=0, busy=0, locked=0, fail=0, all counters 0.
REQ-036 Reset mid-sequence aborts it with no residual state; start is honoured on the first cycle after resetn rises.

Configuration
REQ-037 Macro PLL_LOCK_SEQ_RELOCK_EN defined: in LOCKED, a bad window counts toward a loss counter and a good window clears it; LOCK_COUNT consecutive bad windows -> RESET with counters cleared, same pll_n.
REQ-038 Macro undefined: no loss counter is built; fb_count_valid in LOCKED is ignored and locked stays high until start, stop or reset.

Verification
REQ-039 Reset, then start with n_cfg=32 -> pll_resetn low exactly 12 cycles, high 64 cycles, then busy=1 in MEASURE.
REQ-040 After REQ-039, three strobes with fb_count=128,127,130 -> locked=1 one cycle after the third strobe, busy=0.
REQ-041 Strobes 128,140,128,128,128 -> the bad window resets the good counter; locked one cycle after the fifth strobe.
REQ-042 16 strobes with fb_count=0 -> fail=1, pll_brake=1, pll_resetn=0; start with n_cfg=0 -> FAIL next cycle.
REQ-043 start and stop asserted together in SETTLE -> IDLE next cycle with pll_brake=1.
REQ-044 In LOCKED, 3 strobes with fb_count=200: with RELOCK_EN -> pll_resetn=0 next cycle; without -> locked stays 1.
